prog_clk_divider: RTL and testbench

Parametrised, multi-channel successor to the fixed 50 MHz→100 Hz divider.
- Each of N_CH channels derives a slow clock-enable waveform and a one-cycle tick from the single system clock.
- Divide ratio and high time are programmable per channel.
- New settings are applied glitch-free at the period boundary.
- Feeds display scan, debounce and timer logic in the same clock domain.

---
 rtl/clk_div_pkg.sv | 29 ++
 rtl/clk_div_channel.sv | 114 +++++++++++
 rtl/prog_clk_divider.sv | 40 ++++
 tb/tb_prog_clk_divider.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock-enable divider.
package clk_div_pkg;

  // Reset defaults: 50 MHz system clock divided down to 100 Hz, 50 % duty.
  localparam int unsigned DEF_DIV  = 500000;
  localparam int unsigned DEF_HIGH = 250000;

  // Clamp arithmetic runs at a fixed wide width; channels cast in and out.
  localparam int CW = 64;

  typedef struct packed {
    logic [CW-1:0] d;
    logic [CW-1:0] h;
  } dh_t;

  // Force a requested (D,H) pair into the legal range: D >= 2, H <= D.
  function automatic dh_t clamp_dh(input logic [CW-1:0] d, input logic [CW-1:0] h);
    dh_t r;
    r.d = (d < CW'(2)) ? CW'(2) : d;
    r.h = (h > r.d) ? r.d : h;
    return r;
  endfunction

  // Low bit index of channel ch inside a packed bus of w-bit fields.
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active and pending (D,H) registers,
// registered clk_out / tick / pending outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int          W     = 32,
  parameter int unsigned DEF_D = DEF_DIV,
  parameter int unsigned DEF_H = DEF_HIGH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] div_in,
  input  logic [W-1:0] high_in,
  output logic         clk_out,
  output logic         tick,
  output logic         pending
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] d_act_q, d_act_d;
  logic [W-1:0] h_act_q, h_act_d;
  logic [W-1:0] d_pend_q, d_pend_d;
  logic [W-1:0] h_pend_q, h_pend_d;
  logic         pend_q, pend_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;

  dh_t          cap;
  logic [W-1:0] cap_d;
  logic [W-1:0] cap_h;
  logic         wrap;

  // Next-state: settings only change at a period boundary (or while stopped),
  // so the period in flight is never shortened or stretched.
  always_comb begin
    cap      = clamp_dh(CW'(div_in), CW'(high_in));
    cap_d    = W'(cap.d);
    cap_h    = W'(cap.h);
    wrap     = (cnt_q == d_act_q - W'(1));
    cnt_d    = cnt_q;
    d_act_d  = d_act_q;
    h_act_d  = h_act_q;
    d_pend_d = d_pend_q;
    h_pend_d = h_pend_q;
    pend_d   = pend_q;
    clk_d    = 1'b0;
    tick_d   = 1'b0;
    if (!en) begin
      // Stopped: adopt new settings at once and park the counter so the
      // first enabled edge wraps to 0 and starts a fresh period.
      if (load) begin
        d_act_d = cap_d;
        h_act_d = cap_h;
      end else if (pend_q) begin
        d_act_d = d_pend_q;
        h_act_d = h_pend_q;
      end
      pend_d = 1'b0;
      cnt_d  = d_act_d - W'(1);
    end else begin
      if (wrap) begin
        cnt_d = '0;
        // A load on the wrap edge bypasses the pending stage.
        if (load) begin
          d_act_d = cap_d;
          h_act_d = cap_h;
        end else if (pend_q) begin
          d_act_d = d_pend_q;
          h_act_d = h_pend_q;
        end
        pend_d = 1'b0;
      end else begin
        cnt_d = cnt_q + W'(1);
        if (load) begin
          d_pend_d = cap_d;
          h_pend_d = cap_h;
          pend_d   = 1'b1;
        end
      end
      clk_d  = (cnt_d >= d_act_d - h_act_d);
      tick_d = (cnt_d == '0);
    end
  end

  // State and output registers; reset restores the default 100 Hz setting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= W'(DEF_D - 1);
      d_act_q  <= W'(DEF_D);
      h_act_q  <= W'(DEF_H);
      d_pend_q <= W'(DEF_D);
      h_pend_q <= W'(DEF_H);
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      d_act_q  <= d_act_d;
      h_act_q  <= h_act_d;
      d_pend_q <= d_pend_d;
      h_pend_q <= h_pend_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock-enable divider: N_CH independent channels
// sharing only the system clock and reset.
module prog_clk_divider #(
  parameter int          N_CH     = 2,
  parameter int          W        = 32,
  parameter int unsigned DEF_DIV  = clk_div_pkg::DEF_DIV,
  parameter int unsigned DEF_HIGH = clk_div_pkg::DEF_HIGH
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic [N_CH-1:0]   en,
  input  logic [N_CH*W-1:0] div_in,
  input  logic [N_CH*W-1:0] high_in,
  input  logic [N_CH-1:0]   load,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pending
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam int LO = clk_div_pkg::slice_lo(i, W);

    clk_div_channel #(
      .W     (W),
      .DEF_D (DEF_DIV),
      .DEF_H (DEF_HIGH)
    ) u_ch (
      .clk     (clk_50MHz),
      .rst_n   (reset),
      .en      (en[i]),
      .load    (load[i]),
      .div_in  (div_in[LO +: W]),
      .high_in (high_in[LO +: W]),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Randomised and directed bench for prog_clk_divider. The reference model
// describes each period as a queue of per-cycle (tick,clk_out) values built
// when the period starts, and tracks pending settings separately.
module tb_prog_clk_divider;

  localparam int          N_CH     = 2;
  localparam int          W        = 32;
  localparam int unsigned DEF_DIV  = 500000;
  localparam int unsigned DEF_HIGH = 250000;

  // ---------------- clock / reset ----------------
  logic clk_50MHz;
  logic reset;
  logic [N_CH-1:0]   en;
  logic [N_CH-1:0]   load;
  logic [N_CH*W-1:0] div_in;
  logic [N_CH*W-1:0] high_in;
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   pending;

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  prog_clk_divider #(
    .N_CH     (N_CH),
    .W        (W),
    .DEF_DIV  (DEF_DIV),
    .DEF_HIGH (DEF_HIGH)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .en        (en),
    .div_in    (div_in),
    .high_in   (high_in),
    .load      (load),
    .clk_out   (clk_out),
    .tick      (tick),
    .pending   (pending)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // Each entry: bit1 = tick, bit0 = clk_out for one cycle of the current period.
  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];

  int unsigned m_d[N_CH];
  int unsigned m_h[N_CH];
  int unsigned m_pd[N_CH];
  int unsigned m_ph[N_CH];
  bit          m_pend[N_CH];
  bit          m_clk[N_CH];
  bit          m_tick[N_CH];

  function automatic bit q_empty(input int ch);
    return (ch == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
  endfunction

  function automatic void q_push(input int ch, input logic [1:0] v);
    if (ch == 0) exp_q0.push_back(v);
    else         exp_q1.push_back(v);
  endfunction

  function automatic logic [1:0] q_pop(input int ch);
    if (ch == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic void q_clear(input int ch);
    if (ch == 0) exp_q0.delete();
    else         exp_q1.delete();
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Apply the inputs seen at this clock edge to the model.
  task automatic model_step();
    for (int ch = 0; ch < N_CH; ch++) begin
      int unsigned rd, rh, cd, chh;
      logic [1:0]  v;
      rd  = div_in[ch*W +: W];
      rh  = high_in[ch*W +: W];
      cd  = (rd < 2) ? 2 : rd;
      chh = (rh > cd) ? cd : rh;
      if (!reset) begin
        m_d[ch] = DEF_DIV;  m_h[ch] = DEF_HIGH;
        m_pend[ch] = 1'b0;  q_clear(ch);
        m_clk[ch] = 1'b0;   m_tick[ch] = 1'b0;
      end else if (!en[ch]) begin
        if (load[ch]) begin
          m_d[ch] = cd; m_h[ch] = chh;
        end else if (m_pend[ch]) begin
          m_d[ch] = m_pd[ch]; m_h[ch] = m_ph[ch];
        end
        m_pend[ch] = 1'b0;  q_clear(ch);
        m_clk[ch] = 1'b0;   m_tick[ch] = 1'b0;
      end else begin
        if (q_empty(ch)) begin
          // A new period begins on this edge.
          if (load[ch]) begin
            m_d[ch] = cd; m_h[ch] = chh;
          end else if (m_pend[ch]) begin
            m_d[ch] = m_pd[ch]; m_h[ch] = m_ph[ch];
          end
          m_pend[ch] = 1'b0;
          for (int unsigned k = 0; k < m_d[ch]; k++)
            q_push(ch, {(k == 0), (k >= m_d[ch] - m_h[ch])});
        end else if (load[ch]) begin
          m_pd[ch] = cd; m_ph[ch] = chh; m_pend[ch] = 1'b1;
        end
        v = q_pop(ch);
        m_tick[ch] = v[1];
        m_clk[ch]  = v[0];
      end
    end
  endtask

  task automatic check_all();
    for (int ch = 0; ch < N_CH; ch++) begin
      check($sformatf("clk_out[%0d]", ch), 32'(clk_out[ch]), 32'(m_clk[ch]));
      check($sformatf("tick[%0d]", ch),    32'(tick[ch]),    32'(m_tick[ch]));
      check($sformatf("pending[%0d]", ch), 32'(pending[ch]), 32'(m_pend[ch]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk_50MHz);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_ch(input int ch, input int unsigned d, input int unsigned h);
    div_in[ch*W +: W]  = d;
    high_in[ch*W +: W] = h;
  endtask

  // Single-cycle load strobe on one channel.
  task automatic load_ch(input int ch, input int unsigned d, input int unsigned h);
    set_ch(ch, d, h);
    load[ch] = 1'b1;
    cycle();
    load[ch] = 1'b0;
  endtask

  // Advance until tick[ch] is observed high (cnt==0), bounded.
  task automatic wait_tick(input int ch, input int limit);
    int i;
    i = 0;
    while (tick[ch] !== 1'b1 && i < limit) begin
      cycle();
      i++;
    end
    check($sformatf("wait_tick[%0d]", ch), 32'(tick[ch]), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; en = '0; load = '0; div_in = '0; high_in = '0;
    run(5);

    // Default settings, first edges after release.
    reset = 1'b1; en = 2'b11;
    cycle();
    check("first_tick0", 32'(tick[0]), 32'd1);
    check("first_clk0",  32'(clk_out[0]), 32'd0);
    run(20);

    // Disabled load, then run at D=4,H=2.
    en = 2'b10;
    load_ch(0, 4, 2);
    en = 2'b11;
    run(12);

    // Reload mid-period to D=6,H=3.
    wait_tick(0, 20);
    cycle();
    load_ch(0, 6, 3);
    run(20);

    // Clamping cases, loaded while running.
    load_ch(0, 1, 5);
    run(16);
    load_ch(0, 8, 0);
    run(20);

    // Load exactly on the wrap edge bypasses pending.
    wait_tick(0, 20);
    run(7);
    load_ch(0, 5, 2);
    run(12);
    // Two loads before a boundary: the second wins.
    wait_tick(0, 20);
    load_ch(0, 3, 1);
    load_ch(0, 6, 4);
    run(20);

    // Two channels, reset mid-period, then independent en toggling.
    en = 2'b00;
    set_ch(0, 4, 2); set_ch(1, 10, 7); load = 2'b11;
    cycle();
    load = 2'b00; en = 2'b11;
    run(7);
    reset = 1'b0;
    cycle();
    reset = 1'b1; en = 2'b00; load = 2'b11;
    cycle();
    load = 2'b00; en = 2'b11;
    run(13);
    for (int i = 0; i < 30; i++) begin
      en[1] = ($urandom_range(0, 2) != 0);
      cycle();
    end
    en = 2'b11;
    run(10);

    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0; cycle();
        reset = 1'b1; en = 2'b00;
        set_ch(0, $urandom_range(0, 12), $urandom_range(0, 14));
        set_ch(1, $urandom_range(0, 12), $urandom_range(0, 14));
        load = 2'b11;
        cycle();
        load = 2'b00;
      end else begin
        for (int ch = 0; ch < N_CH; ch++) begin
          en[ch]   = ($urandom_range(0, 7) != 0);
          load[ch] = ($urandom_range(0, 5) == 0);
          set_ch(ch, $urandom_range(0, 12), $urandom_range(0, 14));
        end
        cycle();
        load = 2'b00;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
